// File: rtl/mem_access.sv
// mem_access: memory-access stage of the multi-cycle core.
//
// Captures the ALU result (byte address) on the ALU_kick_up pulse, issues a
// load or store on a req/ready data-memory port, and returns extended load
// data with a one-cycle MEM_kick_up pulse toward write-back.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus and flag MEM_misaligned
//   undefined : the address is aligned down to the access size, MEM_misaligned = 0
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   ALU_result, ALU_kick_up    address / passthrough value and its valid pulse
//   reg_read_data_2            store data
//   Controller_mem*            load/store/size/unsigned controls
//   dmem_req/we/addr/wdata/wstrb, dmem_ready/rdata   data-memory port
//   MEM_read_data, MEM_alu_result, MEM_misaligned, MEM_kick_up   results

module mem_access (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALU_result,
   input  logic        ALU_kick_up,
   input  logic [31:0] reg_read_data_2,
   input  logic        Controller_memread,
   input  logic        Controller_memwrite,
   input  logic [1:0]  Controller_memsize,
   input  logic        Controller_memunsigned,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] MEM_read_data,
   output logic [31:0] MEM_alu_result,
   output logic        MEM_misaligned,
   output logic        MEM_kick_up
);

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   typedef enum logic {StIdle, StReq} state_t;

   state_t      state_q;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic        read_q;
   logic [31:0] alu_q;

   logic        is_word;
   logic        is_half;
   logic        is_mem;
   logic        trap_hit;
   logic [31:0] eff_addr;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Reserved size code 3 behaves as word.
   assign is_word = (Controller_memsize == MEM_SIZE_WORD) || (Controller_memsize == 2'd3);
   assign is_half = (Controller_memsize == MEM_SIZE_HALF);
   assign is_mem  = Controller_memread | Controller_memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned_in;
   logic mis_q;

   assign misaligned_in = (is_half & ALU_result[0]) | (is_word & (ALU_result[1:0] != 2'b00));
   assign trap_hit      = is_mem & misaligned_in;
   assign eff_addr      = ALU_result;
   assign MEM_misaligned = mis_q;
`else
   // No check: drop the low address bits the access size cannot use.
   assign trap_hit = 1'b0;
   assign eff_addr = {ALU_result[31:2],
                      is_word ? 2'b00 : {ALU_result[1], ALU_result[0] & ~is_half}};
   assign MEM_misaligned = 1'b0;
`endif

   // Store steering: replicate data across lanes, strobe only the addressed bytes.
   always_comb begin
      st_wdata = reg_read_data_2;
      st_wstrb = 4'b1111;
      if (is_word) begin
         st_wdata = reg_read_data_2;
         st_wstrb = 4'b1111;
      end else if (is_half) begin
         st_wdata = {2{reg_read_data_2[15:0]}};
         st_wstrb = 4'b0011 << eff_addr[1:0];
      end else begin
         st_wdata = {4{reg_read_data_2[7:0]}};
         st_wstrb = 4'b0001 << eff_addr[1:0];
      end
   end

   // Load extraction from the returned word using the captured offset/size.
   always_comb begin
      ld_byte = dmem_rdata[7:0];
      unique case (off_q)
         2'd0: ld_byte = dmem_rdata[7:0];
         2'd1: ld_byte = dmem_rdata[15:8];
         2'd2: ld_byte = dmem_rdata[23:16];
         2'd3: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      if (size_q == MEM_SIZE_BYTE) begin
         ld_ext = unsigned_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end else if (size_q == MEM_SIZE_HALF) begin
         ld_ext = unsigned_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end else begin
         ld_ext = dmem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         off_q          <= 2'b00;
         size_q         <= 2'b00;
         unsigned_q     <= 1'b0;
         read_q         <= 1'b0;
         alu_q          <= 32'b0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= 32'b0;
         dmem_wdata     <= 32'b0;
         dmem_wstrb     <= 4'b0;
         MEM_read_data  <= 32'b0;
         MEM_alu_result <= 32'b0;
         MEM_kick_up    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         mis_q          <= 1'b0;
`endif
      end else begin
         MEM_kick_up <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ALU_kick_up) begin
                  off_q      <= eff_addr[1:0];
                  size_q     <= Controller_memsize;
                  unsigned_q <= Controller_memunsigned;
                  read_q     <= Controller_memread;
                  alu_q      <= ALU_result;
                  if (!is_mem || trap_hit) begin
                     // Completes without touching the bus.
                     MEM_alu_result <= ALU_result;
                     MEM_read_data  <= 32'b0;
                     MEM_kick_up    <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                     mis_q          <= trap_hit;
`endif
                  end else begin
                     state_q    <= StReq;
                     dmem_req   <= 1'b1;
                     dmem_we    <= ~Controller_memread;
                     dmem_addr  <= {eff_addr[31:2], 2'b00};
                     dmem_wdata <= st_wdata;
                     dmem_wstrb <= Controller_memread ? 4'b0000 : st_wstrb;
                  end
               end
            end
            StReq: begin
               // New ALU_kick_up pulses are ignored while waiting here.
               if (dmem_ready) begin
                  MEM_read_data  <= read_q ? ld_ext : 32'b0;
                  MEM_alu_result <= alu_q;
                  MEM_kick_up    <= 1'b1;
                  dmem_req       <= 1'b0;
                  dmem_we        <= 1'b0;
                  dmem_addr      <= 32'b0;
                  dmem_wdata     <= 32'b0;
                  dmem_wstrb     <= 4'b0;
                  state_q        <= StIdle;
`ifdef MEM_MISALIGN_TRAP_EN
                  mis_q          <= 1'b0;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ALU_result = '0;
   logic        ALU_kick_up = 1'b0;
   logic [31:0] reg_read_data_2 = '0;
   logic        Controller_memread = 1'b0;
   logic        Controller_memwrite = 1'b0;
   logic [1:0]  Controller_memsize = 2'd0;
   logic        Controller_memunsigned = 1'b0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic [31:0] MEM_read_data;
   logic [31:0] MEM_alu_result;
   logic        MEM_misaligned;
   logic        MEM_kick_up;

   always #5 clk = ~clk;

   mem_access dut (
      .clk                    (clk),
      .reset                  (reset),
      .ALU_result             (ALU_result),
      .ALU_kick_up            (ALU_kick_up),
      .reg_read_data_2        (reg_read_data_2),
      .Controller_memread     (Controller_memread),
      .Controller_memwrite    (Controller_memwrite),
      .Controller_memsize     (Controller_memsize),
      .Controller_memunsigned (Controller_memunsigned),
      .dmem_req               (dmem_req),
      .dmem_we                (dmem_we),
      .dmem_addr              (dmem_addr),
      .dmem_wdata             (dmem_wdata),
      .dmem_wstrb             (dmem_wstrb),
      .dmem_ready             (dmem_ready),
      .dmem_rdata             (dmem_rdata),
      .MEM_read_data          (MEM_read_data),
      .MEM_alu_result         (MEM_alu_result),
      .MEM_misaligned         (MEM_misaligned),
      .MEM_kick_up            (MEM_kick_up)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int wait_left = 0;
   logic [31:0] rdata_val = '0;

   typedef struct {
      int          kick_cyc;
      int          req_lo;
      int          req_hi;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rd;
      logic [31:0] alu;
      logic        mis;
   } exp_t;

   exp_t q[$];
   logic [31:0] held_rd = '0;
   logic [31:0] held_alu = '0;
   logic        held_mis = 1'b0;
   int          seen_count = 0;
   logic        seen_we = 1'b0;
   logic [31:0] seen_addr = '0;
   logic [31:0] seen_wdata = '0;
   logic [3:0]  seen_wstrb = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      case (sz)
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_MISALIGN_TRAP_EN
      return a;
`else
      int n;
      n = nbytes(sz);
      return a - 32'(int'(a[1:0]) % n);
`endif
   endfunction

   function automatic logic [3:0] model_strb(input logic [31:0] ea, input logic [1:0] sz,
                                             input logic store);
      logic [3:0] s;
      int o;
      int n;
      s = '0;
      o = int'(ea[1:0]);
      n = nbytes(sz);
      for (int i = 0; i < 4; i++)
         if (store && i >= o && i < o + n) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
      logic [31:0] w;
      int n;
      n = nbytes(sz);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [31:0] ea,
                                              input logic [1:0] sz, input logic uns);
      longint unsigned v;
      longint unsigned mask;
      int n;
      n = nbytes(sz);
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = (64'(rdat) >> (8 * int'(ea[1:0]))) & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   // ---------------- memory responder ----------------
   always @(posedge clk) begin
      #1;
      dmem_rdata = rdata_val;
      if (dmem_req) begin
         if (wait_left > 0) begin
            dmem_ready = 1'b0;
            wait_left  = wait_left - 1;
         end else begin
            dmem_ready = 1'b1;
         end
      end else begin
         dmem_ready = 1'b0;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- compare process ----------------
   always @(negedge clk) begin : cmp
      bit ereq;
      bit ekick;
      if (chk_en) begin
         ereq  = 1'b0;
         ekick = 1'b0;
         if (q.size() > 0) begin
            ereq  = (cyc >= q[0].req_lo) && (cyc <= q[0].req_hi);
            ekick = (cyc == q[0].kick_cyc);
         end
         chk("dmem_req", 32'(dmem_req), 32'(ereq));
         if (ereq) begin
            chk("dmem_we", 32'(dmem_we), 32'(q[0].we));
            chk("dmem_addr", dmem_addr, q[0].addr);
            chk("dmem_wdata", dmem_wdata, q[0].wdata);
            chk("dmem_wstrb", 32'(dmem_wstrb), 32'(q[0].wstrb));
            seen_count = seen_count + 1;
            seen_we    = dmem_we;
            seen_addr  = dmem_addr;
            seen_wdata = dmem_wdata;
            seen_wstrb = dmem_wstrb;
         end
         chk("MEM_kick_up", 32'(MEM_kick_up), 32'(ekick));
         if (ekick) begin
            held_rd  = q[0].rd;
            held_alu = q[0].alu;
            held_mis = q[0].mis;
            void'(q.pop_front());
         end
         chk("MEM_read_data", MEM_read_data, held_rd);
         chk("MEM_alu_result", MEM_alu_result, held_alu);
         chk("MEM_misaligned", 32'(MEM_misaligned), 32'(held_mis));
      end
   end

   // ---------------- driver ----------------
   // Called at 2 time units after a rising edge; returns likewise in the completion cycle.
   task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                        input int waits, input bit extra);
      exp_t        e;
      int          c;
      int          n;
      int          guard;
      bit          mem;
      bit          trap;
      logic [31:0] ea;
      n    = nbytes(sz);
      mem  = rd || wr;
`ifdef MEM_MISALIGN_TRAP_EN
      trap = mem && ((int'(a[1:0]) % n) != 0);
`else
      trap = 1'b0;
`endif
      ea = model_addr(a, sz);
      seen_count = 0;
      ALU_result             = a;
      reg_read_data_2        = d;
      Controller_memread     = rd;
      Controller_memwrite    = wr;
      Controller_memsize     = sz;
      Controller_memunsigned = uns;
      rdata_val              = rdat;
      wait_left              = waits;
      ALU_kick_up            = 1'b1;
      c = cyc;
      e.alu   = a;
      e.mis   = trap;
      e.we    = !rd;
      e.addr  = {ea[31:2], 2'b00};
      e.wdata = model_wdata(d, sz);
      e.wstrb = model_strb(ea, sz, wr && !rd);
      e.rd    = (mem && !trap && rd) ? model_load(rdat, ea, sz, uns) : 32'h0;
      if (mem && !trap) begin
         e.req_lo   = c + 1;
         e.req_hi   = c + 1 + waits;
         e.kick_cyc = c + 2 + waits;
      end else begin
         e.req_lo   = 1;
         e.req_hi   = 0;
         e.kick_cyc = c + 1;
      end
      q.push_back(e);
      @(posedge clk); #2;
      ALU_kick_up = 1'b0;
      guard = 0;
      while (cyc < e.kick_cyc && guard < 200) begin
         @(posedge clk); #2;
         guard++;
         if (extra) begin
            ALU_kick_up = (cyc == c + 2);
            ALU_result  = (cyc == c + 2) ? 32'h0000_BAD0 : a;
         end
      end
      ALU_kick_up = 1'b0;
      ALU_result  = a;
      if (guard >= 200) chk("op_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b0;
      #1;
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_kick", 32'(MEM_kick_up), 32'd0);
      chk("rst_read_data", MEM_read_data, 32'd0);
      chk("rst_alu_result", MEM_alu_result, 32'd0);
      chk("rst_misaligned", 32'(MEM_misaligned), 32'd0);
      chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset  = 1'b1;
      chk_en = 1'b1;

      // word store, ready tied high
      do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
      chk("st_word_count", 32'(seen_count), 32'd1);
      chk("st_word_we", 32'(seen_we), 32'd1);
      chk("st_word_addr", seen_addr, 32'h100);
      chk("st_word_strb", 32'(seen_wstrb), 32'hF);
      chk("st_word_wdata", seen_wdata, 32'hDEADBEEF);

      // byte load 0x103, signed then unsigned
      do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1'b0);
      chk("ld_byte_signed", MEM_read_data, 32'hFFFFFF80);
      do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1'b0);
      chk("ld_byte_unsigned", MEM_read_data, 32'h00000080);

      // half store 0x102
      do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 0, 1'b0);
      chk("st_half_wdata", seen_wdata, 32'hABCDABCD);
      chk("st_half_strb", 32'(seen_wstrb), 32'hC);

      // load with three wait cycles and a stray kick during the wait
      do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h11223344, 3, 1'b1);
      chk("wait_req_cycles", 32'(seen_count), 32'd4);
      chk("wait_alu_result", MEM_alu_result, 32'h200);
      chk("wait_read_data", MEM_read_data, 32'h11223344);

      // misaligned word load at 0x102
      do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_word_req_cycles", 32'(seen_count), 32'd0);
      chk("mis_word_flag", 32'(MEM_misaligned), 32'd1);
      chk("mis_word_data", MEM_read_data, 32'd0);
`else
      chk("mis_word_addr", seen_addr, 32'h100);
      chk("mis_word_flag", 32'(MEM_misaligned), 32'd0);
      chk("mis_word_data", MEM_read_data, 32'hCAFEF00D);
`endif

      // non-memory op
      do_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h42, 32'h0, 32'h0, 0, 1'b0);
      chk("noop_req_cycles", 32'(seen_count), 32'd0);
      chk("noop_alu_result", MEM_alu_result, 32'h42);
      chk("noop_read_data", MEM_read_data, 32'd0);

      // byte store 0x101 with one wait cycle
      do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5, 32'h0, 1, 1'b0);
      chk("st_byte_strb", 32'(seen_wstrb), 32'h2);
      chk("st_byte_wdata", seen_wdata, 32'hA5A5A5A5);

      // half load signed at upper half
      do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80017FFF, 0, 1'b0);
      chk("ld_half_signed", MEM_read_data, 32'hFFFF8001);

      // misaligned half load, unsigned
      do_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 32'h80017FFF, 0, 1'b0);

      // read and write both set: read wins
      do_op(1'b1, 1'b1, 2'd0, 1'b0, 32'h100, 32'h0, 32'h1234567F, 0, 1'b0);
      chk("rw_read_data", MEM_read_data, 32'h0000007F);
      chk("rw_we", 32'(seen_we), 32'd0);

      // reserved size code behaves as word
      do_op(1'b0, 1'b1, 2'd3, 1'b0, 32'h104, 32'h01020304, 32'h0, 0, 1'b0);
      chk("size3_strb", 32'(seen_wstrb), 32'hF);

      // reset asserted while a load waits in REQ
      wait_left              = 5;
      ALU_result             = 32'h300;
      Controller_memread     = 1'b1;
      Controller_memwrite    = 1'b0;
      Controller_memsize     = 2'd2;
      ALU_kick_up            = 1'b1;
      chk_en                 = 1'b0;
      q.delete();
      @(posedge clk); #2;
      ALU_kick_up = 1'b0;
      @(posedge clk); #2;
      chk("pre_reset_req", 32'(dmem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk("midreset_req", 32'(dmem_req), 32'd0);
      chk("midreset_we", 32'(dmem_we), 32'd0);
      chk("midreset_addr", dmem_addr, 32'd0);
      chk("midreset_wdata", dmem_wdata, 32'd0);
      chk("midreset_strb", 32'(dmem_wstrb), 32'd0);
      chk("midreset_alu_result", MEM_alu_result, 32'd0);
      chk("midreset_read_data", MEM_read_data, 32'd0);
      chk("midreset_kick", 32'(MEM_kick_up), 32'd0);
      chk("midreset_misaligned", 32'(MEM_misaligned), 32'd0);
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the multi-cycle core. Accepts the registered ALU result and its one-cycle `ALU_kick_up` pulse from the execute stage, uses the result as a byte address for loads and stores against a ready/request data-memory port, and returns load data with a one-cycle `MEM_kick_up` pulse toward write-back. It performs byte-lane steering, store strobes, load extraction and sign/zero extension, and handles misaligned accesses.

## Interface
- `MEM_SIZE_BYTE`, 2'd0: access size code for byte.
- `MEM_SIZE_HALF`, 2'd1: access size code for halfword.
- `MEM_SIZE_WORD`, 2'd2: access size code for word. Code 2'd3 is reserved and treated as word.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ALU_result`  in  32  byte address for loads/stores, or passthrough value.
- `ALU_kick_up`  in  1  one-cycle pulse; `ALU_result` is valid this cycle.
- `reg_read_data_2`  in  32  store data.
- `Controller_memread`  in  1  instruction is a load.
- `Controller_memwrite`  in  1  instruction is a store. Read has priority if both are set.
- `Controller_memsize`  in  2  access size code.
- `Controller_memunsigned`  in  1  zero-extend loads when 1, sign-extend when 0.
- `dmem_req`  out  1  memory request, held until accepted.
- `dmem_we`  out  1  1 = write, 0 = read.
- `dmem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_wstrb`  out  4  byte write strobes. All 0 on reads.
- `dmem_ready`  in  1  memory accepts or completes the request this cycle.
- `dmem_rdata`  in  32  read word, valid when `dmem_ready`=1 on a read.
- `MEM_read_data`  out  32  extended load data. 0 for non-loads.
- `MEM_alu_result`  out  32  captured `ALU_result`.
- `MEM_misaligned`  out  1  the completed access was misaligned.
- `MEM_kick_up`  out  1  one-cycle completion pulse.

## Operation
- Reset state: FSM in IDLE. All outputs are 0.
- States: IDLE, REQ.
- **IDLE**
  - When `ALU_kick_up`=1, capture the address, store data and control signals.
  - No memory op: update `MEM_alu_result`, set `MEM_read_data`=0, pulse `MEM_kick_up` next cycle, stay in IDLE.
  - Misaligned op: same as a no-op, and set `MEM_misaligned`=1 (see Configuration).
  - Otherwise: go to REQ.
- **REQ**
  - `dmem_req`=1, with `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb` stable.
  - When `dmem_ready` is sampled 1:
    - register load data, or 0 for a store;
    - pulse `MEM_kick_up`;
    - drop `dmem_req`;
    - go to IDLE.
- Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Store steering:
  - byte: `wdata={4{d[7:0]}}`, `wstrb=4'b0001<<addr[1:0]`.
  - half: `wdata={2{d[15:0]}}`, `wstrb=4'b0011<<addr[1:0]`.
  - word: `wdata=d`, `wstrb=4'b1111`.
- Load extraction:
  - byte: `rdata[8*addr[1:0]+:8]`.
  - half: `rdata[16*addr[1]+:16]`.
  - Both are extended per `Controller_memunsigned`.
- `ALU_kick_up` arriving in REQ is ignored. The stage is never re-entered while busy.
- `MEM_read_data`, `MEM_alu_result` and `MEM_misaligned` hold until the next completion.

## Timing
- No-op or misaligned access: `MEM_kick_up` is high in the cycle after the `ALU_kick_up` edge (latency 1).
- Memory access:
  - `dmem_req` rises in the cycle after capture.
  - With `dmem_ready` tied high, `MEM_kick_up` follows 2 cycles after `ALU_kick_up`. Each wait cycle adds 1.
- `MEM_kick_up` is never high for two consecutive cycles.
- The next `ALU_kick_up` is accepted on the edge after `MEM_kick_up` rises.
- Reset asserted mid-REQ: `dmem_req` and all outputs go to 0 immediately (asynchronously). The pending access is abandoned.

## Configuration
- `MEM_MISALIGN_TRAP_EN`
  - Defined: misaligned accesses never reach the bus and set `MEM_misaligned`=1 for that completion.
  - Undefined: no misalignment check. The address is aligned down to the access size (half `addr[0]`→0, word `addr[1:0]`→0), the access is performed normally, and `MEM_misaligned` is tied 0.

## Test plan
- Word store, `ALU_result`=0x100, data 0xDEADBEEF, `dmem_ready` tied 1 -> `dmem_req` for 1 cycle with `we`=1, addr 0x100, `wstrb`=1111; `MEM_kick_up` 2 cycles after `ALU_kick_up`.
- Byte load with sign extension, addr 0x103, `rdata`=0x80FF_FF7F -> `MEM_read_data`=0xFFFFFF80. With `Controller_memunsigned`=1 -> 0x00000080.
- Half store, addr 0x102, data 0x1234ABCD -> `wdata`=0xABCDABCD, `wstrb`=1100.
- Load with `dmem_ready` low for 3 cycles -> `dmem_req` held 4 cycles with stable addr; `MEM_kick_up` 5 cycles after `ALU_kick_up`. A second `ALU_kick_up` during the wait is ignored.
- Word load at 0x102:
  - with `MEM_MISALIGN_TRAP_EN`: no `dmem_req`, `MEM_misaligned`=1, `MEM_kick_up` after 1 cycle;
  - without: read at 0x100, `MEM_misaligned`=0.
- Non-memory op, `ALU_result`=0x42 -> no `dmem_req`, `MEM_alu_result`=0x42, `MEM_kick_up` after 1 cycle. Reset pulled low mid-REQ -> all outputs 0 immediately.
